// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO push port among NumReq valid/ready producers.
// Define FIFO_PUSH_ARBITER_TAG_EN to prepend the owner index to every FIFO entry.
module fifo_push_arbiter #(
   parameter int unsigned NumReq       = 4,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned BurstLen     = 4,
   parameter int unsigned ReqIdWidth   = $clog2(NumReq),
   parameter int unsigned BeatCntWidth = $clog2(BurstLen) + 1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clr_i,
   input  logic [NumReq*DataWidth-1:0]     req_data_i,
   input  logic [NumReq-1:0]               req_valid_i,
   output logic [NumReq-1:0]               req_ready_o,
   input  logic                            fifo_full_i,
   output logic                            fifo_push_o,
`ifdef FIFO_PUSH_ARBITER_TAG_EN
   output logic [DataWidth+ReqIdWidth-1:0] fifo_data_o,
`else
   output logic [DataWidth-1:0]            fifo_data_o,
`endif
   output logic [NumReq-1:0]               grant_o,
   output logic [ReqIdWidth-1:0]           grant_id_o,
   output logic                            busy_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [ReqIdWidth-1:0]   grant_id_q, grant_id_d;
   logic [NumReq-1:0]       grant_q, grant_d;
   logic [ReqIdWidth-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BeatCntWidth-1:0] beat_cnt_q, beat_cnt_d;

   logic [DataWidth-1:0]    req_data_a [NumReq];
   logic [DataWidth-1:0]    owner_data;
   logic                    owner_valid;
   logic                    push_c;
   logic                    last_beat;
   logic                    release_c;
   logic [ReqIdWidth-1:0]   next_ptr;

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign req_data_a[g] = req_data_i[g*DataWidth +: DataWidth];
   end

   // First valid requester at or after ptr, wrapping; lowest offset wins.
   function automatic logic [ReqIdWidth-1:0] rr_pick(input logic [NumReq-1:0]     valid,
                                                     input logic [ReqIdWidth-1:0] ptr);
      logic [ReqIdWidth-1:0] pick;
      int                    idx;
      pick = ptr;
      for (int k = int'(NumReq) - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= int'(NumReq)) idx = idx - int'(NumReq);
         if (valid[idx]) pick = ReqIdWidth'(idx);
      end
      return pick;
   endfunction

   always_comb begin
      owner_data  = req_data_a[grant_id_q];
      owner_valid = req_valid_i[grant_id_q];
      push_c      = (state_q == ST_BURST) && owner_valid && !fifo_full_i;
      last_beat   = (beat_cnt_q == BeatCntWidth'(BurstLen - 1));
      release_c   = (push_c && last_beat) || !owner_valid;
      next_ptr    = (grant_id_q == ReqIdWidth'(NumReq - 1)) ? '0 : grant_id_q + 1'b1;
   end

   // Next-state: grant on any valid from IDLE; in BURST count beats and hand over on release.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               state_d    = ST_BURST;
               grant_id_d = rr_pick(req_valid_i, rr_ptr_q);
               beat_cnt_d = '0;
            end
         end
         ST_BURST: begin
            if (push_c) beat_cnt_d = beat_cnt_q + BeatCntWidth'(1);
            if (release_c) begin
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
               if (|req_valid_i) begin
                  grant_id_d = rr_pick(req_valid_i, next_ptr);
               end else begin
                  state_d    = ST_IDLE;
                  grant_id_d = '0;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_id_d = '0;
         end
      endcase
      grant_d = (state_d == ST_BURST) ? (NumReq'(1) << grant_id_d) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         state_q    <= ST_IDLE;
         grant_id_q <= '0;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Push/ready/data follow the registered owner combinationally.
   always_comb begin
      busy_o      = (state_q == ST_BURST);
      grant_o     = grant_q;
      grant_id_o  = grant_id_q;
      fifo_push_o = push_c;
      req_ready_o = fifo_full_i ? '0 : grant_q;
`ifdef FIFO_PUSH_ARBITER_TAG_EN
      fifo_data_o = busy_o ? {grant_id_q, owner_data} : '0;
`else
      fifo_data_o = busy_o ? owner_data : '0;
`endif
   end

`ifndef SYNTHESIS
   logic [NumReq-1:0]    chk_hold_q, chk_hold_d;
   logic [DataWidth-1:0] chk_data_q [NumReq];
   logic [DataWidth-1:0] chk_data_d [NumReq];

   always_comb begin
      chk_hold_d = (!rst_ni || clr_i) ? '0 : (req_valid_i & ~req_ready_o);
      chk_data_d = req_data_a;
   end

   // Producers must hold payload while stalled; grant stays one-hot; never push into a full FIFO.
   always_ff @(posedge clk_i) begin
      chk_hold_q <= chk_hold_d;
      chk_data_q <= chk_data_d;
      if (rst_ni && !clr_i) begin
         assert ($onehot0(grant_o)) else $error("grant_o not one-hot: %b", grant_o);
         assert (!(fifo_push_o && fifo_full_i)) else $error("push while FIFO full");
         for (int i = 0; i < int'(NumReq); i++) begin
            if (chk_hold_q[i] && req_valid_i[i]) begin
               assert (chk_data_q[i] == req_data_a[i])
                  else $error("requester %0d changed data while stalled", i);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized and directed bench for fifo_push_arbiter against a cycle-level reference model.
// Honours FIFO_PUSH_ARBITER_TAG_EN for the width and layout of fifo_data_o.
module tb_fifo_push_arbiter;

   localparam int unsigned NumReq    = 4;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned BurstLen  = 4;
   localparam int unsigned IdW       = 2;
`ifdef FIFO_PUSH_ARBITER_TAG_EN
   localparam int unsigned OutW = DataWidth + IdW;
`else
   localparam int unsigned OutW = DataWidth;
`endif

   logic                        clk_i;
   logic                        rst_ni;
   logic                        clr_i;
   logic [NumReq*DataWidth-1:0] req_data_i;
   logic [NumReq-1:0]           req_valid_i;
   logic [NumReq-1:0]           req_ready_o;
   logic                        fifo_full_i;
   logic                        fifo_push_o;
   logic [OutW-1:0]             fifo_data_o;
   logic [NumReq-1:0]           grant_o;
   logic [IdW-1:0]              grant_id_o;
   logic                        busy_o;

   fifo_push_arbiter #(
      .NumReq   (NumReq),
      .DataWidth(DataWidth),
      .BurstLen (BurstLen)
   ) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (clr_i),
      .req_data_i (req_data_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .fifo_full_i(fifo_full_i),
      .fifo_push_o(fifo_push_o),
      .fifo_data_o(fifo_data_o),
      .grant_o    (grant_o),
      .grant_id_o (grant_id_o),
      .busy_o     (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int                   n_vec = 0;
   int                   n_err = 0;
   int                   m_owner;   // -1 when idle
   int                   m_ptr;
   int                   m_beats;
   logic [DataWidth-1:0] pay [NumReq];
   bit                   const_pay;
   bit                   log_en;
   logic [DataWidth-1:0] push_log[$];
   int                   push_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_search(input logic [NumReq-1:0] v, input int start);
      for (int k = 0; k < int'(NumReq); k++) begin
         if (v[(start + k) % int'(NumReq)]) return (start + k) % int'(NumReq);
      end
      return -1;
   endfunction

   // One clock: drive, check outputs against the model, then advance the model past the edge.
   task automatic cycle(input logic [NumReq-1:0] v, input logic full, input logic rst, input logic clr);
      logic                 busy;
      logic                 exp_push;
      logic [NumReq-1:0]    exp_ready;
      logic [NumReq-1:0]    exp_grant;
      logic [IdW-1:0]       exp_id;
      logic [OutW-1:0]      exp_data;
      bit                   rel;
      @(negedge clk_i);
      req_valid_i = v;
      fifo_full_i = full;
      rst_ni      = ~rst;
      clr_i       = clr;
      for (int i = 0; i < int'(NumReq); i++) req_data_i[i*DataWidth +: DataWidth] = pay[i];
      #1;
      busy      = (m_owner >= 0);
      exp_push  = busy && v[m_owner] && !full;
      exp_grant = busy ? (NumReq'(1) << m_owner) : '0;
      exp_ready = (busy && !full) ? exp_grant : '0;
      exp_id    = busy ? IdW'(m_owner) : '0;
`ifdef FIFO_PUSH_ARBITER_TAG_EN
      exp_data  = busy ? {IdW'(m_owner), pay[m_owner]} : '0;
`else
      exp_data  = busy ? pay[m_owner] : '0;
`endif
      check_eq("push",     64'(fifo_push_o), 64'(exp_push));
      check_eq("ready",    64'(req_ready_o), 64'(exp_ready));
      check_eq("grant",    64'(grant_o),     64'(exp_grant));
      check_eq("grant_id", 64'(grant_id_o),  64'(exp_id));
      check_eq("busy",     64'(busy_o),      64'(busy));
      check_eq("data",     64'(fifo_data_o), 64'(exp_data));
      if (log_en && fifo_push_o) push_log.push_back(fifo_data_o[DataWidth-1:0]);
      if (fifo_push_o) push_cnt++;
      if (!const_pay) begin
         for (int i = 0; i < int'(NumReq); i++)
            if (exp_ready[i] && v[i]) pay[i] = $urandom;
      end
      if (rst || clr) begin
         m_owner = -1; m_ptr = 0; m_beats = 0;
      end else if (m_owner < 0) begin
         m_owner = rr_search(v, m_ptr);
         m_beats = 0;
      end else begin
         rel = 0;
         if (exp_push) begin
            m_beats++;
            if (m_beats == int'(BurstLen)) rel = 1;
         end
         if (!v[m_owner]) rel = 1;
         if (rel) begin
            m_ptr   = (m_owner + 1) % int'(NumReq);
            m_owner = rr_search(v, m_ptr);
            m_beats = 0;
         end
      end
   endtask

   initial begin
      rst_ni = 1'b0; clr_i = 1'b0; fifo_full_i = 1'b0;
      req_valid_i = '0; req_data_i = '0;
      const_pay = 1; log_en = 0; push_cnt = 0;
      for (int i = 0; i < int'(NumReq); i++) pay[i] = 32'h100 + i;
      repeat (2) @(posedge clk_i);
      m_owner = -1; m_ptr = 0; m_beats = 0;

      // Reset state, then req0 alone for 6 beats
      cycle('0, 0, 0, 0);
      cycle('0, 0, 0, 0);
      push_cnt = 0;
      repeat (7) cycle(4'b0001, 0, 0, 0);
      repeat (2) cycle(4'b0000, 0, 0, 0);
      check_eq("solo_push_count", 64'(push_cnt), 64'd6);

      // All valid, fixed payloads: 4 beats per owner in round-robin order
      for (int i = 0; i < int'(NumReq); i++) pay[i] = 32'hA0 + i;
      cycle('0, 0, 1, 0);
      push_log.delete();
      log_en = 1;
      repeat (21) cycle(4'b1111, 0, 0, 0);
      log_en = 0;
      check_eq("rr_log_len", 64'(push_log.size()), 64'd20);
      for (int k = 0; k < 20 && k < push_log.size(); k++)
         check_eq($sformatf("rr_order[%0d]", k), 64'(push_log[k]), 64'(32'hA0 + (k / 4) % 4));

      // req1 stalled by full after beat 2
      cycle('0, 0, 1, 0);
      push_cnt = 0;
      repeat (3) cycle(4'b0010, 0, 0, 0);
      repeat (3) cycle(4'b0010, 1, 0, 0);
      repeat (2) cycle(4'b0010, 0, 0, 0);
      check_eq("stall_push_count", 64'(push_cnt), 64'd4);
      cycle('0, 0, 0, 0);
      cycle('0, 0, 0, 0);

      // req2 drops after one beat while req0 waits
      cycle('0, 0, 1, 0);
      cycle(4'b0100, 0, 0, 0);
      cycle(4'b0101, 0, 0, 0);
      cycle(4'b0001, 0, 0, 0);
      cycle(4'b0001, 0, 0, 0);
      check_eq("drop_rr_ptr", 64'(m_ptr), 64'd3);

      // Mid-burst reset, then mid-burst clear
      repeat (6) cycle(4'b1110, 0, 0, 0);
      cycle(4'b1110, 0, 1, 0);
      repeat (6) cycle(4'b1111, 0, 0, 0);
      cycle(4'b1111, 0, 0, 1);
      repeat (3) cycle(4'b1111, 0, 0, 0);

      // req3 payload, tagged with its index when tagging is enabled
      cycle('0, 0, 1, 0);
      pay[3] = 32'h12345678;
      cycle(4'b1000, 0, 0, 0);
      cycle(4'b1000, 0, 0, 0);
`ifdef FIFO_PUSH_ARBITER_TAG_EN
      check_eq("tag_data", 64'(fifo_data_o), 64'({2'd3, 32'h12345678}));
`else
      check_eq("tag_data", 64'(fifo_data_o), 64'(32'h12345678));
`endif
      cycle('0, 0, 0, 0);

      // Random traffic with stalls, drops, resets and clears
      const_pay = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [NumReq-1:0] v;
         for (int i = 0; i < int'(NumReq); i++) v[i] = ($urandom_range(0, 9) < 7);
         cycle(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0),
               ($urandom_range(0, 149) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin, burst-locking arbiter that shares the push port of one common FIFO among NumReq valid/ready producers.
- Sits between the requesters (encoder, item-memory, etc. streams) and the FIFO's data_i/push_i/full_o interface.
- Holds a grant for up to BurstLen accepted beats, so one producer's data stays contiguous in the queue.
- Rotates priority fairly after each burst.

Parameters:
NumReq, 4, number of requesters (>=2)
DataWidth, 32, payload width per requester
BurstLen, 4, max beats pushed per grant (>=1)
ReqIdWidth, $clog2(NumReq), derived; do not override
BeatCntWidth, $clog2(BurstLen)+1, derived; do not override

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
clr_i  input  1  synchronous soft clear, same effect as reset
req_data_i  input  NumReq*DataWidth  flattened payloads, requester i at [i*DataWidth +: DataWidth]
req_valid_i  input  NumReq  per-requester valid
req_ready_o  output  NumReq  per-requester ready
fifo_full_i  input  1  FIFO full flag
fifo_push_o  output  1  FIFO push strobe
fifo_data_o  output  DataWidth (+ReqIdWidth with tag)  FIFO write data
grant_o  output  NumReq  one-hot current owner, all-zero when idle
grant_id_o  output  ReqIdWidth  index of current owner
busy_o  output  1  high in BURST state

Behaviour:
- Reset or clr_i (clr_i has priority over all other events): state=IDLE, grant_o=0, grant_id_o=0, rr_ptr=0, beat_cnt=0. Outputs follow immediately: fifo_push_o=0, req_ready_o=0, busy_o=0.
- Arbitration: combinational RR pick over req_valid_i, searching from rr_ptr upward with wrap. The winner is registered, giving 1 cycle of grant latency from IDLE.
- IDLE:
  - Any valid -> BURST with owner=winner, beat_cnt=0.
  - No valid -> stay IDLE.
- BURST:
  - req_ready_o[owner] = ~fifo_full_i; all other ready bits 0.
  - fifo_push_o = req_valid_i[owner] & ~fifo_full_i.
  - fifo_data_o = owner payload, multiplexed combinationally.
  - An accepted beat (push) increments beat_cnt.
- Release conditions, evaluated every BURST cycle:
  - (a) push with beat_cnt==BurstLen-1, or
  - (b) req_valid_i[owner]==0.
- On release:
  - rr_ptr = owner+1, wrapping NumReq-1 -> 0.
  - Re-arbitrate the same cycle from the new rr_ptr. The former owner is eligible only in condition (a), and only if no other requester is valid.
  - Winner found -> stay BURST, new owner, beat_cnt=0, no bubble. None -> IDLE.
- fifo_full_i stall: no push, beat_cnt held, grant held. Condition (b) still releases.
- fifo_push_o is never asserted while fifo_full_i=1. This makes the FIFO's full-write check unreachable.
- Valid/data contract: requesters must not change data while valid && !ready. This is asserted in sim only.
- grant_o is always one-hot or zero.
- Outside BURST, fifo_data_o = 0.

Optional Feature:
Macro: FIFO_PUSH_ARBITER_TAG_EN.
- Defined: fifo_data_o is DataWidth+ReqIdWidth wide, laid out as {grant_id_o, payload}. Consumers can demux entries by source.
- Undefined: fifo_data_o is DataWidth wide, payload only.
- Arbitration and timing are identical in both modes.

Test Plan:
- Only req0 valid for 6 beats, BurstLen=4, FIFO never full -> cycle 0 idle; 4 pushes, back-to-back re-grant of req0 with no bubble, 2 more pushes, then IDLE.
- req0..req3 all continuously valid, each data=0xA0+i -> push order 4x0xA0, 4x0xA1, 4x0xA2, 4x0xA3, 4x0xA0; grant_id_o sequence 0,1,2,3,0.
- req1 owner, fifo_full_i high for 3 cycles after beat 2 -> fifo_push_o=0 and req_ready_o=0 during the stall, beat_cnt stays 2; beats 3-4 then pushed, then release.
- req2 owner drops valid after 1 beat while req0 is valid -> release that cycle, grant moves to req0 next cycle, rr_ptr=3.
- Mid-burst rst_ni=0 for 1 cycle (then clr_i=1 in a second run) -> next cycle grant_o=0, fifo_push_o=0, busy_o=0; re-arbitration starts from req0.
- With FIFO_PUSH_ARBITER_TAG_EN, req3 pushes 0x12345678 -> fifo_data_o = {2'd3, 32'h12345678}.
